// File: rtl/capture_scheduler_if.sv
// Bus bundle between the ADC capture scheduler, its sample source, buffer RAM and frame consumer.
// The scheduler connects through the slave modport; the environment uses master.
interface capture_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int HALF_DEPTH = 64
);
  localparam int ADDR_WIDTH = $clog2(2 * HALF_DEPTH);

  logic                  eoc;
  logic [DATA_WIDTH-1:0] adc_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  frame_valid;
  logic                  frame_start;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic [7:0]            overrun_cnt;

  modport slave (
    input  eoc, adc_data, ram_rdata, frame_start,
    output ram_addr, ram_wdata, ram_we, frame_valid, rd_data, rd_valid, rd_last, overrun_cnt
  );

  modport master (
    output eoc, adc_data, ram_rdata, frame_start,
    input  ram_addr, ram_wdata, ram_we, frame_valid, rd_data, rd_valid, rd_last, overrun_cnt
  );
endinterface

// File: rtl/capture_scheduler.sv
// Ping-pong ADC capture into a single-port buffer with a streaming reader.
// Sample writes always win the RAM port; the reader stalls for one cycle per write.
module capture_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int HALF_DEPTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  capture_scheduler_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(2 * HALF_DEPTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(HALF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_e;

  rd_state_e             state_q, state_d;
  logic                  eoc_s1_q, eoc_s1_d, eoc_s2_q, eoc_s2_d, eoc_s3_q, eoc_s3_d;
  logic                  whalf_q, whalf_d, rhalf_q, rhalf_d, pend_q, pend_d;
  logic [IDX_WIDTH-1:0]  fill_q, fill_d, ridx_q, ridx_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic                  issue_q, issue_d, issue_last_q, issue_last_d;
  logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [7:0]            overrun_cnt_q, overrun_cnt_d;
  logic                  eoc_edge, release_hit, reader_busy;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    eoc_s1_d      = bus.eoc;
    eoc_s2_d      = eoc_s1_q;
    eoc_s3_d      = eoc_s2_q;
    whalf_d       = whalf_q;
    rhalf_d       = rhalf_q;
    pend_d        = pend_q;
    fill_d        = fill_q;
    ridx_d        = ridx_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_we_d      = 1'b0;
    issue_d       = 1'b0;
    issue_last_d  = 1'b0;
    overrun_cnt_d = overrun_cnt_q;

    eoc_edge    = eoc_s2_q & ~eoc_s3_q;
    release_hit = (state_q == DRAIN) && rd_valid_q && rd_last_q;
    // A release in this cycle frees the reader before the write boundary is judged.
    reader_busy = pend_q && !release_hit;

    if (release_hit) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end

    if (eoc_edge) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = {whalf_q, fill_q};
      ram_wdata_d = bus.adc_data;
      fill_d      = fill_q + 1'b1;
      if (fill_q == LAST_IDX) begin
        fill_d = '0;
        if (!reader_busy) begin
          pend_d  = 1'b1;
          rhalf_d = whalf_q;
          whalf_d = ~whalf_q;
        end else if (overrun_cnt_q != 8'hFF) begin
          overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.frame_start && frame_valid_q) begin
          state_d = READ;
          ridx_d  = '0;
        end
      end
      READ: begin
        if (!eoc_edge) begin
          ram_addr_d   = {rhalf_q, ridx_q};
          issue_d      = 1'b1;
          issue_last_d = (ridx_q == LAST_IDX);
          ridx_d       = ridx_q + 1'b1;
          if (ridx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      default: ;
    endcase

    // Read data arrives one cycle after the address leaves the port.
    rd_valid_d    = issue_q;
    rd_last_d     = issue_last_q;
    frame_valid_d = pend_d && (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; all of it resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      eoc_s1_q      <= 1'b0;
      eoc_s2_q      <= 1'b0;
      eoc_s3_q      <= 1'b0;
      whalf_q       <= 1'b0;
      rhalf_q       <= 1'b0;
      pend_q        <= 1'b0;
      fill_q        <= '0;
      ridx_q        <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      issue_q       <= 1'b0;
      issue_last_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      eoc_s1_q      <= eoc_s1_d;
      eoc_s2_q      <= eoc_s2_d;
      eoc_s3_q      <= eoc_s3_d;
      whalf_q       <= whalf_d;
      rhalf_q       <= rhalf_d;
      pend_q        <= pend_d;
      fill_q        <= fill_d;
      ridx_q        <= ridx_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_we_q      <= ram_we_d;
      issue_q       <= issue_d;
      issue_last_q  <= issue_last_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      frame_valid_q <= frame_valid_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_last     = rd_last_q;
  assign bus.rd_data     = rd_valid_q ? bus.ram_rdata : '0;
  assign bus.overrun_cnt = overrun_cnt_q;
endmodule

// File: tb/tb_capture_scheduler.sv
// Randomised directed bench for capture_scheduler against a frame-level model of
// the ping-pong buffer, with a synchronous RAM model on the buffer port.
module tb_capture_scheduler;
  localparam int DW = 8;
  localparam int HD = 64;
  localparam int AW = $clog2(2 * HD);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  capture_scheduler_if #(.DATA_WIDTH(DW), .HALF_DEPTH(HD)) bus ();
  capture_scheduler #(.DATA_WIDTH(DW), .HALF_DEPTH(HD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Synchronous single-port buffer: read data valid the cycle after the address.
  logic [DW-1:0] mem [2*HD];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  logic [AW+DW-1:0] wr_q[$];
  logic [DW:0]      beat_q[$];
  int               beat_cyc[$];
  int               cyc = 0;

  always @(negedge clk) begin
    if (bus.ram_we) wr_q.push_back({bus.ram_addr, bus.ram_wdata});
    if (bus.rd_valid) begin
      beat_q.push_back({bus.rd_last, bus.rd_data});
      beat_cyc.push_back(cyc);
    end
    cyc++;
  end

  // Frame-level reference model.
  int               m_whalf, m_fill, m_rhalf, m_ovr;
  bit               m_pend;
  logic [DW-1:0]    m_mem [2*HD];
  logic [AW+DW-1:0] exp_wr[$];
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_whalf = 0; m_fill = 0; m_rhalf = 0; m_ovr = 0; m_pend = 0;
    exp_wr.delete();
  endtask

  task automatic model_sample(input logic [DW-1:0] d);
    int a;
    a = m_whalf * HD + m_fill;
    exp_wr.push_back({AW'(a), d});
    m_mem[a] = d;
    if (m_fill == HD - 1) begin
      m_fill = 0;
      if (!m_pend) begin
        m_pend  = 1;
        m_rhalf = m_whalf;
        m_whalf = 1 - m_whalf;
      end else if (m_ovr < 255) begin
        m_ovr++;
      end
    end else begin
      m_fill++;
    end
  endtask

  task automatic pulse(input logic [DW-1:0] d, input int hi);
    tick();
    bus.adc_data = d;
    bus.eoc      = 1'b1;
    repeat (hi) tick();
    bus.eoc = 1'b0;
    repeat ($urandom_range(3, 5)) tick();
    model_sample(d);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      check({tag, "_wr"}, wr_q[i], exp_wr[i]);
    wr_q.delete();
    exp_wr.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beat_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("beat_count", beat_q.size(), n);
  endtask

  task automatic check_beats(input int n);
    for (int i = 0; i < n && i < beat_q.size(); i++) begin
      check("rd_data", beat_q[i][DW-1:0], m_mem[m_rhalf * HD + i]);
      check("rd_last", beat_q[i][DW], (i == HD - 1));
    end
  endtask

  task automatic start_frame();
    beat_q.delete();
    beat_cyc.delete();
    tick();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.eoc = 1'b0; bus.adc_data = '0; bus.frame_start = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_last", bus.rd_last, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_frame_valid", bus.frame_valid, 0);
    check("rst_overrun", bus.overrun_cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // frame_start with nothing pending is ignored.
    start_frame();
    repeat (10) tick();
    check("idle_no_beats", beat_q.size(), 0);

    // 64 samples 0..63 fill half 0 and make it pending.
    for (int i = 0; i < HD; i++) pulse(DW'(i), $urandom_range(1, 4));
    check_writes("fill0");
    check("fv_after_fill", bus.frame_valid, 1);
    check("ovr_after_fill", bus.overrun_cnt, 0);

    // Stream half 0 while five more samples land in half 1.
    start_frame();
    check("fv_during_read", bus.frame_valid, 0);
    for (int i = 0; i < 5; i++) pulse(DW'($urandom), $urandom_range(1, 4));
    wait_beats(HD, 300);
    check_beats(HD);
    if (beat_cyc.size() == HD) check("stall_span", beat_cyc[HD-1] - beat_cyc[0], HD - 1 + 5);
    repeat (3) tick();
    m_pend = 0;
    check("fv_after_read", bus.frame_valid, 0);
    check_writes("wr_during_read");

    // Complete half 1, then overfill half 0 while half 1 waits.
    for (int i = 0; i < HD - 5; i++) pulse(DW'($urandom), $urandom_range(1, 4));
    check("fv_half1", bus.frame_valid, 1);
    for (int i = 0; i < HD; i++) pulse(DW'($urandom), $urandom_range(1, 4));
    check("ovr_one", bus.overrun_cnt, m_ovr);
    check("ovr_is_1", bus.overrun_cnt, 1);
    check_writes("overfill");

    // Reset mid-readout after beat 20.
    start_frame();
    wait_beats(20, 100);
    check_beats(20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_valid", bus.rd_valid, 0);
    check("mid_rst_frame_valid", bus.frame_valid, 0);
    check("mid_rst_overrun", bus.overrun_cnt, 0);
    check("mid_rst_ram_we", bus.ram_we, 0);
    repeat (2) tick();
    model_reset();
    wr_q.delete();
    beat_q.delete();
    rst_n = 1'b1;
    repeat (10) tick();
    check("post_rst_no_beats", beat_q.size(), 0);

    // 192 samples with no readout from a clean state.
    for (int i = 0; i < 3 * HD; i++) begin
      pulse(DW'($urandom), $urandom_range(1, 4));
      if (i == 2 * HD - 1) check("ovr_after_128", bus.overrun_cnt, 1);
    end
    check("ovr_after_192", bus.overrun_cnt, m_ovr);
    check("fv_after_192", bus.frame_valid, 1);
    check_writes("overrun192");
    start_frame();
    wait_beats(HD, 200);
    check_beats(HD);
    repeat (3) tick();
    m_pend = 0;

    // A long eoc level is a single sample.
    pulse(8'hA5, 10);
    check_writes("held_eoc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
